// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider generator.
package clk_div_pkg;

    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_if.sv
// Ratio-update handshake between a configuring master and the divider.
interface clk_div_if #(parameter int CNT_W = clk_div_pkg::DEF_CNT_W);

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_ratio;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_ratio, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ratio, output cfg_ready);

endinterface

// File: rtl/clk_div_cnt.sv
// Half-period counter: counts up from zero, flags when it reaches the limit.
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == limit);

endmodule

// File: rtl/clk_div_gen.sv
// Glitch-free programmable clock divider; ratio changes and stops only take effect at period boundaries.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    clk_div_if.slave cfg,
    output logic     clk_out,
    output logic     clk_out_inv,
    output logic     rise_tick,
    output logic     busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             clk_out_inv_q, clk_out_inv_d;
    logic             rise_tick_q, rise_tick_d;
    logic             accept;
    logic             cnt_clear;
    logic             tc;
    logic [CNT_W-1:0] cnt;

    assign cnt_clear = (state_q == IDLE) || tc;

    clk_div_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .limit (ratio_q),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_comb begin
        state_d       = state_q;
        ratio_d       = ratio_q;
        pend_d        = pend_q;
        clk_out_d     = clk_out_q;
        clk_out_inv_d = clk_out_inv_q;
        rise_tick_d   = 1'b0;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    ratio_d = cfg.cfg_ratio;
                end
                if (en) begin
                    state_d       = RUN;
                    clk_out_d     = 1'b1;
                    clk_out_inv_d = 1'b0;
                    rise_tick_d   = 1'b1;
                end
            end
            default: begin
                accept = (state_q == RUN) && cfg.cfg_valid;
                if (accept) begin
                    pend_d  = cfg.cfg_ratio;
                    state_d = PEND;
                end
                if (tc) begin
                    if (clk_out_q) begin
                        clk_out_d     = 1'b0;
                        clk_out_inv_d = 1'b1;
                    end else begin
                        if (state_q == PEND) begin
                            ratio_d = pend_q;
                        end
                        if (en) begin
                            clk_out_d     = 1'b1;
                            clk_out_inv_d = 1'b0;
                            rise_tick_d   = 1'b1;
                            if (!accept) begin
                                state_d = RUN;
                            end
                        end else begin
                            // Stopping: a ratio accepted on this very edge lands directly, as it would in IDLE.
                            state_d = IDLE;
                            if (accept) begin
                                ratio_d = cfg.cfg_ratio;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ratio_q       <= '0;
            pend_q        <= '0;
            clk_out_q     <= 1'b0;
            clk_out_inv_q <= 1'b1;
            rise_tick_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ratio_q       <= ratio_d;
            pend_q        <= pend_d;
            clk_out_q     <= clk_out_d;
            clk_out_inv_q <= clk_out_inv_d;
            rise_tick_q   <= rise_tick_d;
        end
    end

    assign clk_out       = clk_out_q;
    assign clk_out_inv   = clk_out_inv_q;
    assign rise_tick     = rise_tick_q;
    assign busy          = (state_q != IDLE);
    assign cfg.cfg_ready = (state_q != PEND);

endmodule

// File: tb/tb_clk_div_gen.sv
// Randomized bench for clk_div_gen against a phase-countdown reference model.
module tb_clk_div_gen;

    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    logic en;
    logic clk_out;
    logic clk_out_inv;
    logic rise_tick;
    logic busy;

    int compare_count;
    int mismatch_count;

    // Reference model: remaining cycles of the current output phase.
    bit m_run;
    bit m_level;
    int m_left;
    int m_ratio;
    bit m_pend_v;
    int m_pend;
    bit m_tick;

    clk_div_if #(.CNT_W(CNT_W)) cfg_if ();

    clk_div_gen #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg         (cfg_if.slave),
        .clk_out     (clk_out),
        .clk_out_inv (clk_out_inv),
        .rise_tick   (rise_tick),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic modelStep(input bit r, input bit e, input bit v, input int c);
        bit accept;
        bit boundary;
        if (!r) begin
            m_run = 0; m_level = 0; m_left = 0; m_ratio = 0;
            m_pend_v = 0; m_pend = 0; m_tick = 0;
        end else if (!m_run) begin
            m_tick = 0;
            if (v) m_ratio = c;
            if (e) begin
                m_run = 1; m_level = 1; m_left = m_ratio + 1; m_tick = 1;
            end
        end else begin
            accept   = v && !m_pend_v;
            boundary = (m_left == 1) && !m_level;
            m_tick   = 0;
            if (m_left > 1) begin
                m_left--;
            end else if (m_level) begin
                m_level = 0;
                m_left  = m_ratio + 1;
            end else begin
                if (m_pend_v) begin
                    m_ratio  = m_pend;
                    m_pend_v = 0;
                end
                if (e) begin
                    m_level = 1; m_left = m_ratio + 1; m_tick = 1;
                end else begin
                    m_run = 0;
                end
            end
            if (accept) begin
                if (boundary && !e) begin
                    m_ratio = c;
                end else begin
                    m_pend   = c;
                    m_pend_v = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit v, input int c);
        rst_n            = r;
        en               = e;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_ratio = CNT_W'(c);
        @(posedge clk);
        modelStep(r, e, v, c);
        #1;
        checkOutput("clk_out", {31'd0, clk_out}, {31'd0, m_level});
        checkOutput("clk_out_inv", {31'd0, clk_out_inv}, {31'd0, ~m_level});
        checkOutput("rise_tick", {31'd0, rise_tick}, {31'd0, m_tick});
        checkOutput("busy", {31'd0, busy}, {31'd0, m_run});
        checkOutput("cfg_ready", {31'd0, cfg_if.cfg_ready}, {31'd0, !(m_run && m_pend_v)});
    endtask

    task automatic runCycles(input int n, input bit e);
        for (int i = 0; i < n; i++) applyStimulus(1, e, 0, 0);
    endtask

    task automatic resetAndLoad(input int r);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 1, r);
    endtask

    initial begin
        logic [15:0] pattern;
        compare_count  = 0;
        mismatch_count = 0;
        m_run = 0; m_level = 0; m_left = 0; m_ratio = 0; m_pend_v = 0; m_pend = 0; m_tick = 0;

        // R=3 from IDLE: fixed 4-high/4-low waveform from the first run edge.
        resetAndLoad(3);
        pattern = '0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1, 0, 0);
            pattern = {pattern[14:0], clk_out};
        end
        checkOutput("pattern_r3", {16'd0, pattern}, 32'h0000_F0F0);
        runCycles(8, 1);

        // Switch to R=0 while running, then observe the clk/2 output.
        applyStimulus(1, 1, 1, 0);
        runCycles(12, 1);

        // Mid-high-phase ratio update.
        resetAndLoad(3);
        runCycles(3, 1);
        applyStimulus(1, 1, 1, 1);
        runCycles(20, 1);

        // Stop request one cycle into the high phase.
        resetAndLoad(2);
        applyStimulus(1, 1, 0, 0);
        runCycles(15, 0);

        // Stop cancelled before the boundary.
        resetAndLoad(5);
        runCycles(3, 1);
        runCycles(4, 0);
        runCycles(30, 1);

        // Reset during a high phase with an update pending.
        resetAndLoad(3);
        runCycles(2, 1);
        applyStimulus(1, 1, 1, 1);
        applyStimulus(0, 1, 0, 0);
        runCycles(6, 0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 11) == 0),
                          $urandom_range(0, 9));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter: CNT_W, default 8, width of divide ratio and half-period counter.
REQ-002 Port: clk  input  1  sole clock; all flops on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: en  input  1  run request; 1 = generate divided clock, 0 = stop at next period boundary.
REQ-005 Port: cfg_ratio  input  CNT_W  new half-period ratio R; half-period = R+1 clk cycles.
REQ-006 Port: cfg_valid  input  1  cfg_ratio valid.
REQ-007 Port: cfg_ready  output  1  ratio update accepted when cfg_valid & cfg_ready.
REQ-008 Port: clk_out  output  1  divided clock, registered.
REQ-009 Port: clk_out_inv  output  1  complement of clk_out from its own flop; feeds downstream clk_inv input.
REQ-010 Port: rise_tick  output  1  one-cycle pulse, high in the cycle clk_out first reads 1 after a low phase or IDLE.
REQ-011 Port: busy  output  1  1 when state is not IDLE.

Function
REQ-012 States: IDLE, RUN, PEND (RUN with latched ratio update awaiting boundary).
REQ-013 cfg_ready SHALL be 1 in IDLE and RUN, 0 in PEND.
REQ-014 Handshake in IDLE: cfg_ratio loads into active ratio on the accepting edge; state stays IDLE.
REQ-015 Handshake in RUN: cfg_ratio loads into pending register; RUN -> PEND.
REQ-016 IDLE -> RUN on edge sampling en=1: clk_out<=1, clk_out_inv<=0, cnt<=0, rise_tick<=1.
REQ-017 In RUN/PEND, cnt increments each cycle; when cnt==ratio, cnt<=0 and clk_out/clk_out_inv toggle.
REQ-018 Output high and low phases SHALL each last exactly ratio+1 clk cycles; R=0 gives clk/2.
REQ-019 Period boundary: cnt==ratio with clk_out==0 (edge where clk_out would rise).
REQ-020 At boundary in PEND: active ratio <= pending, state -> RUN, cnt<=0; new ratio governs the high phase starting this edge.
REQ-021 At boundary with en==0: clk_out stays 0, clk_out_inv stays 1, state -> IDLE, cnt<=0, no rise_tick; a pending ratio is applied to active ratio.
REQ-022 en deasserted mid-period SHALL NOT truncate the current period; no phase shorter than ratio+1 cycles ever appears.
REQ-023 en re-asserted before boundary SHALL cancel the stop; output continues uninterrupted.
REQ-024 cfg accepted on the boundary edge itself (from RUN) SHALL go to PEND and apply at the next boundary.
REQ-025 clk_out_inv == ~clk_out in every cycle after reset.
REQ-026 No combinational path from inputs to clk_out, clk_out_inv, rise_tick.

Reset
REQ-027 On clk edge with rst_n==0: state IDLE, cnt 0, active and pending ratio 0, clk_out 0, clk_out_inv 1, rise_tick 0, busy 0, cfg_ready 1.
REQ-028 Reset asserted mid-period SHALL take effect on the next edge regardless of phase; first run after reset starts per REQ-016.

Structure
REQ-029 Shared package clk_div_pkg holds state enum (IDLE, RUN, PEND) and default CNT_W constant.
REQ-030 One sub-module natural: clk_div_cnt (half-period counter with load/clear/terminal-count flag); FSM and outputs in clk_div_gen.

Verification
REQ-031 Reset, cfg R=3 in IDLE, en=1 -> clk_out 4 high/4 low repeating, rise_tick every 8 cycles, clk_out_inv always complementary.
REQ-032 R=0, en=1 -> clk_out toggles every cycle (period 2), busy=1.
REQ-033 Running R=3, cfg R=1 accepted mid-high-phase -> cfg_ready 0 until boundary; current period 8 cycles, then period 4.
REQ-034 Running R=2, en dropped 1 cycle into high phase -> 3 high, 3 low, then IDLE with clk_out=0, busy=0, no further rise_tick.
REQ-035 Running R=5, en dropped then re-raised before boundary -> uninterrupted period-12 waveform.
REQ-036 rst_n low mid-high phase with pending cfg -> next edge clk_out=0, clk_out_inv=1, cfg_ready=1, ratio 0.
